// File: rtl/divider32.sv
// 32-bit signed/unsigned restoring divider with valid/ready request and response channels.
// Latency: response visible 33 cycles after request handshake; divide-by-zero and signed overflow in 1 cycle.
// Backpressure: one operation in flight; request ready only when idle, result held until rsp_ready_i.
module divider32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        signed_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        div_by_zero_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [31:0] rem_q;      // partial remainder
    logic [31:0] quo_q;      // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] dsr_q;      // divisor magnitude
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        req_hs;
    logic        rsp_hs;
    logic        dividend_neg;
    logic        divisor_neg;
    logic [31:0] dvd_mag;
    logic [31:0] dsr_mag;
    logic        div_zero;
    logic        ovf;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == DONE);
    assign req_hs      = req_valid_i && req_ready_o;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;

    // Operand decode: magnitudes and special cases. -0x80000000 wraps to 2^31, which is the
    // correct unsigned magnitude, so the most negative dividend needs no extra bit here.
    assign dividend_neg = signed_i & dividend_i[31];
    assign divisor_neg  = signed_i & divisor_i[31];
    assign dvd_mag      = dividend_neg ? (32'd0 - dividend_i) : dividend_i;
    assign dsr_mag      = divisor_neg  ? (32'd0 - divisor_i)  : divisor_i;
    assign div_zero     = (divisor_i == 32'd0);
    assign ovf          = signed_i && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);

    // One restoring step: shift in next dividend bit, 33-bit trial subtract, keep or restore.
    assign rem_sh  = {rem_q, quo_q[31]};
    assign diff    = rem_sh - {1'b0, dsr_q};
    assign fits    = ~diff[32];
    assign rem_nxt = fits ? diff[31:0] : rem_sh[31:0];
    assign quo_nxt = {quo_q[30:0], fits};
    assign q_fin   = neg_quo_q ? (32'd0 - quo_nxt) : quo_nxt;
    assign r_fin   = neg_rem_q ? (32'd0 - rem_nxt) : rem_nxt;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_hs) begin
                    state_nxt = (div_zero || ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on handshake, iterate in CALC, publish result on the last step.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt           <= 5'd0;
            rem_q         <= 32'd0;
            quo_q         <= 32'd0;
            dsr_q         <= 32'd0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            quotient_o    <= 32'd0;
            remainder_o   <= 32'd0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        if (div_zero) begin
                            quotient_o    <= 32'hFFFF_FFFF;
                            remainder_o   <= dividend_i;
                            div_by_zero_o <= 1'b1;
                        end else if (ovf) begin
                            quotient_o    <= 32'h8000_0000;
                            remainder_o   <= 32'd0;
                            div_by_zero_o <= 1'b0;
                        end else begin
                            cnt       <= 5'd0;
                            rem_q     <= 32'd0;
                            quo_q     <= dvd_mag;
                            dsr_q     <= dsr_mag;
                            neg_quo_q <= dividend_neg ^ divisor_neg;
                            neg_rem_q <= dividend_neg;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        quotient_o    <= q_fin;
                        remainder_o   <= r_fin;
                        div_by_zero_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider32.sv
module tb_divider32;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        signed_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_by_zero_o;

    int checks = 0;
    int errors = 0;

    divider32 dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .signed_i      (signed_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'd0};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int stall, input string tag);
        logic [64:0] exp;
        int          lat;
        int          exp_lat;
        exp     = ref_div(a, b, s);
        exp_lat = (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(negedge clk_i);
        chk($sformatf("%s_req_ready", tag), {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        dividend_i  = a;
        divisor_i   = b;
        signed_i    = s;
        rsp_ready_i = (stall == 0);
        @(posedge clk_i);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (rsp_valid_o) break;
            // Junk on the request port while busy must be ignored.
            req_valid_i = 1'($urandom_range(0, 1));
            dividend_i  = $urandom;
            divisor_i   = $urandom;
            signed_i    = 1'($urandom_range(0, 1));
        end
        req_valid_i = 1'b0;
        chk($sformatf("%s_latency", tag), lat, exp_lat);
        chk($sformatf("%s_quotient", tag), quotient_o, exp[63:32]);
        chk($sformatf("%s_remainder", tag), remainder_o, exp[31:0]);
        chk($sformatf("%s_dbz", tag), {31'd0, div_by_zero_o}, {31'd0, exp[64]});
        for (int i = 0; i < stall; i++) begin
            req_valid_i = 1'b1;
            dividend_i  = $urandom;
            divisor_i   = $urandom;
            @(negedge clk_i);
            chk($sformatf("%s_hold_valid%0d", tag, i), {31'd0, rsp_valid_o}, 32'd1);
            chk($sformatf("%s_hold_ready%0d", tag, i), {31'd0, req_ready_o}, 32'd0);
            chk($sformatf("%s_hold_q%0d", tag, i), quotient_o, exp[63:32]);
            chk($sformatf("%s_hold_r%0d", tag, i), remainder_o, exp[31:0]);
            chk($sformatf("%s_hold_dbz%0d", tag, i), {31'd0, div_by_zero_o}, {31'd0, exp[64]});
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        chk($sformatf("%s_idle_valid", tag), {31'd0, rsp_valid_o}, 32'd0);
        chk($sformatf("%s_idle_ready", tag), {31'd0, req_ready_o}, 32'd1);
        chk($sformatf("%s_idle_q", tag), quotient_o, exp[63:32]);
    endtask

    initial begin
        int          busy_seen;
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;

        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        dividend_i  = 32'd0;
        divisor_i   = 32'd0;
        signed_i    = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_quotient", quotient_o, 32'd0);
        chk("rst_remainder", remainder_o, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
        rst_ni = 1'b1;

        // Directed cases.
        run_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0, "u_fff9_2");
        run_op(32'd5, 32'd0, 1'b0, 0, "u5_0");
        run_op(32'd5, 32'd0, 1'b1, 0, "s5_0");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_min_max");
        run_op(32'h8000_0000, 32'd2, 1'b1, 0, "s_min_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s7_m2");
        run_op(32'd1000, 32'd33, 1'b0, 5, "stall");
        run_op(32'd9, 32'd0, 1'b1, 5, "stall_dbz");

        // Reset in the middle of a calculation.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        dividend_i  = 32'd100;
        divisor_i   = 32'd7;
        signed_i    = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("abort_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("abort_quotient", quotient_o, 32'd0);
        chk("abort_remainder", remainder_o, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero_o}, 32'd0);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o || !req_ready_o) busy_seen++;
        end
        chk("abort_no_response", busy_seen, 32'd0);
        run_op(32'd9, 32'd3, 1'b0, 0, "after_abort");

        // Randomized operations against the reference.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            s    = 1'($urandom_range(0, 1));
            case (kind)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 15);
                4: b = 32'd0 - $urandom_range(1, 15);
                default: ;
            endcase
            run_op(a, b, s, (n % 7 == 3) ? 2 : 0, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider32.md
DIVIDER32 -- requirements
Module: divider32

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 32 bits.
REQ-002 clk_i  in  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 req_valid_i  in  1  request present.
REQ-005 req_ready_o  out  1  block can accept a request.
REQ-006 dividend_i  in  32  numerator; sampled only on request handshake.
REQ-007 divisor_i  in  32  denominator; sampled only on request handshake.
REQ-008 signed_i  in  1  1 = two's-complement operands, 0 = unsigned; sampled on handshake.
REQ-009 rsp_valid_o  out  1  result present.
REQ-010 rsp_ready_i  in  1  consumer accepts result.
REQ-011 quotient_o  out  32  quotient.
REQ-012 remainder_o  out  32  remainder.
REQ-013 div_by_zero_o  out  1  divisor was zero; valid while rsp_valid_o=1.

Function
REQ-014 Request handshake SHALL occur on an edge where req_valid_i=1 and req_ready_o=1; response handshake on an edge where rsp_valid_o=1 and rsp_ready_i=1.
REQ-015 FSM SHALL have states IDLE, CALC and DONE; req_ready_o=1 only in IDLE, rsp_valid_o=1 only in DONE.
REQ-016 IDLE -> CALC on request handshake with divisor non-zero and not signed overflow; IDLE -> DONE directly for divide-by-zero or signed overflow.
REQ-017 CALC SHALL last exactly 32 cycles driven by a 5-bit iteration counter, then -> DONE.
REQ-018 DONE -> IDLE on response handshake; while rsp_ready_i=0, all outputs SHALL hold stable.
REQ-019 Normal latency: rsp_valid_o SHALL rise 33 cycles after the request-handshake edge; special cases 1 cycle.
REQ-020 Each CALC cycle SHALL perform one restoring step: partial remainder shifted left 1 with next dividend MSB; 33-bit trial subtract of divisor magnitude; if non-negative keep difference and set quotient bit 1, else restore and set 0.
REQ-021 Signed mode SHALL divide magnitudes; quotient negated if operand signs differ; remainder takes dividend's sign (truncating division).
REQ-022 Divisor zero: quotient_o=0xFFFFFFFF, remainder_o=dividend_i, div_by_zero_o=1, either mode.
REQ-023 Signed overflow (0x80000000 / 0xFFFFFFFF, signed_i=1): quotient_o=0x80000000, remainder_o=0, div_by_zero_o=0.
REQ-024 Dividend 0x80000000 in signed mode with any other divisor SHALL use magnitude 2^31 without overflow (33-bit internal path).
REQ-025 Inputs SHALL be ignored outside IDLE; a new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-026 quotient_o/remainder_o SHALL hold last result in IDLE; their value is defined only while rsp_valid_o=1.

Reset
REQ-027 rst_ni=0 SHALL immediately force state IDLE, counter 0, req_ready_o=1, rsp_valid_o=0, div_by_zero_o=0, quotient_o=0, remainder_o=0, independent of clk_i.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation; no response for it SHALL ever appear.
REQ-029 After rst_ni deasserts, a request SHALL be accepted on the first clock edge with req_valid_i=1.

Verification
REQ-030 Unsigned 100/7, rsp_ready_i=1 -> rsp_valid_o 33 cycles after handshake, quotient_o=14, remainder_o=2, div_by_zero_o=0.
REQ-031 Signed 0xFFFFFFF9 / 2 (-7/2) -> quotient_o=0xFFFFFFFD (-3), remainder_o=0xFFFFFFFF (-1); same operands unsigned -> quotient_o=0x7FFFFFFC, remainder_o=1.
REQ-032 5/0 either mode -> rsp_valid_o 1 cycle after handshake, quotient_o=0xFFFFFFFF, remainder_o=5, div_by_zero_o=1.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> 1-cycle latency, quotient_o=0x80000000, remainder_o=0; signed 0x80000000 / 2 -> quotient_o=0xC0000000, remainder_o=0 after 33 cycles.
REQ-034 rsp_ready_i held 0 for 5 cycles in DONE -> outputs stable, req_ready_o=0, req_valid_i pulses ignored; rsp_ready_i=1 -> IDLE next cycle.
REQ-035 rst_ni pulsed low at CALC cycle 10 -> rsp_valid_o=0 and req_ready_o=1 immediately; subsequent 9/3 request returns quotient_o=3, remainder_o=0.
